// File: rtl/bar_chart_sequencer_pkg.sv
// Shared definitions for the bar chart sequencer slice.
//  - sequencer state encodings
//  - default colours, screen limits, coordinate widths
//  - drawer configuration struct (start point + height)
//  - bar_left_x(): left edge x of a bar given origin/pitch/index
package bar_chart_sequencer_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int XW       = 9;
  localparam int YW       = 8;
  localparam int HW       = 7;
  localparam int CW       = 3;
  localparam int BAR_W    = 8;

  localparam logic [CW-1:0] DEF_BAR_COLOUR = 3'b010;
  localparam logic [CW-1:0] DEF_BG_COLOUR  = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ERASE_INIT,
    S_ERASE,
    S_DRAW_INIT,
    S_DRAW,
    S_NEXT
  } seq_state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [HW-1:0] height;
  } drw_cfg_t;

  function automatic logic [XW-1:0] bar_left_x(input int origin, input int pitch, input int idx);
    return XW'(origin + idx * pitch);
  endfunction

endpackage

// File: rtl/bar_chart_sequencer_display.sv
// bar_graph_display: pixel counter core for one bar-shaped rectangle.
// Walks an 8-pixel-wide block of (height+1) rows starting at cfg.x/cfg.y,
// row by row, left to right. One pixel per enabled cycle; done flags the
// last pixel while it is being presented.
// Ports:
//  clk, resetn  clock / async active-low reset
//  clr          synchronous counter clear (drawer local reset)
//  enable       advance one pixel per cycle
//  cfg          start x/y and height (rows-1), held stable during a pass
//  x, y         current pixel coordinate (combinational from counters)
//  done         enable && current pixel is the last one
module bar_graph_display
  import bar_chart_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          enable,
  input  drw_cfg_t      cfg,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          done
);

  logic [2:0]    xc;
  logic [HW-1:0] yc;
  logic          last;

  assign last = (xc == 3'(BAR_W - 1)) && (yc == cfg.height);
  assign done = enable && last;
  assign x    = cfg.x + XW'(xc);
  assign y    = cfg.y + YW'(yc);

  // Counters park on the last pixel until the sequencer clears them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xc <= '0;
      yc <= '0;
    end else if (clr) begin
      xc <= '0;
      yc <= '0;
    end else if (enable && !last) begin
      if (xc == 3'(BAR_W - 1)) begin
        xc <= '0;
        yc <= yc + HW'(1);
      end else begin
        xc <= xc + 3'd1;
      end
    end
  end

endmodule

// File: rtl/bar_chart_sequencer.sv
// bar_chart_sequencer: walks a history RAM of NUM_BARS heights and, per bar,
// erases its column to background then redraws it at the stored height.
// Ports:
//  clk, resetn  clock / async active-low reset
//  start        1-cycle pulse, starts one chart update (ignored while busy)
//  hist_addr    history RAM read address (bar index)
//  hist_data    bar height, valid one cycle after hist_addr
//  x_out,y_out  pixel coordinate from the drawer
//  colour       pixel colour
//  plot         pixel write strobe
//  busy         frame update in progress
//  done         1-cycle pulse after the last pixel of the last bar
module bar_chart_sequencer
  import bar_chart_sequencer_pkg::*;
#(
  parameter int            NUM_BARS   = 8,
  parameter int            ORIGIN_X   = 20,
  parameter int            BAR_PITCH  = 10,
  parameter int            BASELINE_Y = 200,
  parameter int            MAX_H      = 100,
  parameter logic [CW-1:0] BAR_COLOUR = DEF_BAR_COLOUR,
  parameter logic [CW-1:0] BG_COLOUR  = DEF_BG_COLOUR,
  localparam int           AW         = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic [AW-1:0] hist_addr,
  input  logic [HW-1:0] hist_data,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  if (ORIGIN_X + (NUM_BARS - 1) * BAR_PITCH + BAR_W - 1 >= SCREEN_W) begin : g_bad_x
    $error("bar_chart_sequencer: rightmost bar exceeds screen width");
  end
  if (BASELINE_Y >= SCREEN_H || BASELINE_Y - MAX_H < 0 || MAX_H > 127) begin : g_bad_y
    $error("bar_chart_sequencer: vertical geometry out of range");
  end

  localparam logic [HW-1:0] MAX_H7   = HW'(MAX_H);
  localparam logic [YW-1:0] BASE8    = YW'(BASELINE_Y);
  localparam logic [YW-1:0] ERASE_Y0 = YW'(BASELINE_Y - MAX_H);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BARS - 1);

  seq_state_e    state;
  logic [AW-1:0] idx;
  logic [HW-1:0] h;
  drw_cfg_t      cfg;
  logic          drw_clr;
  logic          drw_done;

  // Drawer is held cleared everywhere except while it is actually plotting,
  // so it is fresh at the start of every erase/draw pass and after reset.
  assign drw_clr = (state != S_ERASE) && (state != S_DRAW);

  bar_graph_display u_drw (
    .clk    (clk),
    .resetn (resetn),
    .clr    (drw_clr),
    .enable (plot),
    .cfg    (cfg),
    .x      (x_out),
    .y      (y_out),
    .done   (drw_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      hist_addr <= '0;
      h         <= '0;
      cfg       <= '0;
      colour    <= BG_COLOUR;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high in the first idle cycle: a start coinciding
          // with the done pulse is treated as arriving during busy.
          if (start && !done) begin
            idx       <= '0;
            hist_addr <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          h     <= (hist_data > MAX_H7) ? MAX_H7 : hist_data;
          state <= S_ERASE_INIT;
        end
        S_ERASE_INIT: begin
          cfg.x      <= bar_left_x(ORIGIN_X, BAR_PITCH, int'(idx));
          cfg.y      <= ERASE_Y0;
          cfg.height <= MAX_H7;
          colour     <= BG_COLOUR;
          plot       <= 1'b1;
          state      <= S_ERASE;
        end
        S_ERASE: begin
          if (drw_done) begin
            plot  <= 1'b0;
            state <= S_DRAW_INIT;
          end
        end
        S_DRAW_INIT: begin
          cfg.y      <= BASE8 - YW'(h);
          cfg.height <= h;
          colour     <= BAR_COLOUR;
          plot       <= 1'b1;
          state      <= S_DRAW;
        end
        S_DRAW: begin
          if (drw_done) begin
            plot  <= 1'b0;
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            idx       <= idx + AW'(1);
            hist_addr <= idx + AW'(1);
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
